// File: rtl/cf_math_pkg.sv
// Shared math helpers for index and width sizing.
//   idx_width(n): bits needed to index n items (at least 1).
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? 32'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/popcount.sv
// Population count of a bit vector.
//   data_i     : input vector
//   popcount_o : number of set bits in data_i
module popcount #(
  parameter  int unsigned INPUT_WIDTH   = 256,
  localparam int unsigned PopcountWidth = $clog2(INPUT_WIDTH) + 1
) (
  input  logic [INPUT_WIDTH-1:0]   data_i,
  output logic [PopcountWidth-1:0] popcount_o
);

  // Plain adder chain; synthesis rebalances it into a tree.
  always_comb begin
    popcount_o = '0;
    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
      popcount_o = popcount_o + PopcountWidth'(data_i[i]);
    end
  end

endmodule

// File: rtl/p2_stride_seq.sv
// Power-of-two slide pass sequencer. Splits a slide stride into its set bits
// (supplied by an external generator) and issues one datapath pass per bit,
// lowest bit first, tracking the offset already slid.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_i            : synchronous abort back to idle
//   req_*              : slide request handshake and stride
//   gen_load_o/stride_o: load the generator with the request stride
//   gen_update_o       : advance the generator to its next component
//   gen_popc_i/stride_p2_i/valid_i : generator component count, component, valid
//   pass_*             : pass handshake to the datapath (stride, offset, first, last)
//   done_o/npasses_o/err_o : registered completion pulse, pass count, error flag
module p2_stride_seq #(
  parameter  int unsigned NrLanes = 0,
  localparam int unsigned W       = cf_math_pkg::idx_width(8 * NrLanes),
  localparam int unsigned PW      = cf_math_pkg::idx_width(W) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [W-1:0]  req_stride_i,
  output logic          gen_load_o,
  output logic [W-1:0]  gen_stride_o,
  output logic          gen_update_o,
  input  logic [PW-1:0] gen_popc_i,
  input  logic [W-1:0]  gen_stride_p2_i,
  input  logic          gen_valid_i,
  output logic          pass_valid_o,
  input  logic          pass_ready_i,
  output logic [W-1:0]  pass_stride_o,
  output logic [W-1:0]  pass_offset_o,
  output logic          pass_first_o,
  output logic          pass_last_o,
  output logic          done_o,
  output logic [PW-1:0] npasses_o,
  output logic          err_o
);

  localparam int unsigned PopW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    stride_q, acc_q;
  logic [PW-1:0]   count_q, target_q;
  logic            err_q;
  logic [PopW-1:0] comp_popc;
  logic            comp_bad_c, issue_err_c, last_c;

  // One-hot check on the current generator component.
  popcount #(
    .INPUT_WIDTH(W)
  ) i_popcount (
    .data_i    (gen_stride_p2_i),
    .popcount_o(comp_popc)
  );

  // A component is malformed if it is not one-hot or repeats an issued bit.
  assign comp_bad_c  = (comp_popc != PopW'(1)) || ((gen_stride_p2_i & acc_q) != '0);
  assign issue_err_c = (state_q == ISSUE) &&
                       ((!gen_valid_i && (count_q < target_q)) || (gen_valid_i && comp_bad_c));
  assign last_c      = ((count_q + PW'(1)) == target_q);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake decode; malformed components never handshake.
  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    gen_load_o    = 1'b0;
    gen_stride_o  = '0;
    gen_update_o  = 1'b0;
    pass_valid_o  = 1'b0;
    pass_stride_o = '0;
    pass_offset_o = '0;
    pass_first_o  = 1'b0;
    pass_last_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = ~flush_i;
        if (req_valid_i && !flush_i) begin
          gen_load_o   = 1'b1;
          gen_stride_o = req_stride_i;
          state_d      = LOAD;
        end
      end
      LOAD: state_d = (gen_popc_i == '0) ? DONE : ISSUE;
      ISSUE: begin
        pass_stride_o = gen_stride_p2_i;
        pass_offset_o = acc_q;
        pass_first_o  = (count_q == '0);
        pass_last_o   = last_c;
        if (issue_err_c) begin
          state_d = DONE;
        end else if (gen_valid_i && !flush_i) begin
          pass_valid_o = 1'b1;
          if (pass_ready_i) begin
            gen_update_o = 1'b1;
            if (last_c) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Request context, pass accounting and registered completion outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stride_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      target_q  <= '0;
      err_q     <= 1'b0;
      done_o    <= 1'b0;
      npasses_o <= '0;
      err_o     <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      npasses_o <= '0;
      err_o     <= 1'b0;
      if (gen_load_o) begin
        stride_q <= req_stride_i;
        acc_q    <= '0;
        count_q  <= '0;
        target_q <= '0;
        err_q    <= 1'b0;
      end
      if (state_q == LOAD && !flush_i) target_q <= gen_popc_i;
      if (issue_err_c && !flush_i) err_q <= 1'b1;
      if (gen_update_o) begin
        acc_q   <= acc_q | gen_stride_p2_i;
        count_q <= count_q + PW'(1);
      end
      // Completion also flags a stride the issued passes did not cover.
      if (state_q == DONE && !flush_i) begin
        done_o    <= 1'b1;
        npasses_o <= count_q;
        err_o     <= err_q | (acc_q != stride_q);
      end
    end
  end

endmodule

// File: doc/p2_stride_seq.md
P2_STRIDE_SEQ -- requirements
Module: p2_stride_seq

Interface
REQ-001 SHALL have parameter NrLanes, default 0, meaning number of lanes; W = idx_width(8*NrLanes), PW = idx_width(W)+1.
REQ-002 SHALL have ports, in this order:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort.
- req_valid_i  in  1  slide request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_stride_i  in  W  total slide stride in bytes.
- gen_load_o  out  1  load strobe to the power-of-two stride generator.
- gen_stride_o  out  W  stride forwarded to the generator.
- gen_update_o  out  1  request for the next power-of-two component.
- gen_popc_i  in  PW  generator component count.
- gen_stride_p2_i  in  W  current one-hot component.
- gen_valid_i  in  1  component non-zero.
- pass_valid_o  out  1  slide pass request to the datapath.
- pass_ready_i  in  1  datapath accepts the pass.
- pass_stride_o  out  W  pass shift amount.
- pass_offset_o  out  W  sum of already-issued passes.
- pass_first_o  out  1  first pass of the request.
- pass_last_o  out  1  last pass of the request.
- done_o  out  1  one-cycle completion pulse.
- npasses_o  out  PW  passes issued for the completed request.
- err_o  out  1  protocol error; valid together with done_o.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, ISSUE, DONE.
REQ-004 SHALL drive req_ready_o = (state==IDLE) & ~flush_i.
REQ-005 SHALL, on request handshake, drive gen_load_o=1 and gen_stride_o=req_stride_i combinationally, capture the stride, clear the accumulator and pass counter, and go to LOAD.
REQ-006 SHALL, in LOAD, capture gen_popc_i into a target count; target 0 goes to DONE with npasses 0, otherwise go to ISSUE; pass_valid_o stays low in LOAD.
REQ-007 SHALL drive pass_valid_o = gen_valid_i in ISSUE, with pass_stride_o = gen_stride_p2_i.
REQ-008 SHALL, on pass handshake, pulse gen_update_o for exactly that cycle, OR the component into the accumulator, and increment the pass counter.
REQ-009 SHALL issue back-to-back passes with no bubble: the generator presents the next component the cycle after an update.
REQ-010 SHALL issue passes in ascending bit order; stride 6 gives 2 then 4.
REQ-011 SHALL assert pass_first_o when count==0 and pass_last_o when count+1==target.
REQ-012 SHALL move ISSUE to DONE on the handshake with pass_last_o set.
REQ-013 SHALL, in ISSUE, set the error flag and go to DONE on any of:
- gen_valid_i low while count<target;
- gen_stride_p2_i not one-hot;
- gen_stride_p2_i overlapping the accumulator.
REQ-014 SHALL, in DONE, pulse done_o for one cycle and return to IDLE.
REQ-015 SHALL, in DONE, set err_o |= (accumulator != captured stride) and drive npasses_o = count.
REQ-016 SHALL, on flush_i in any state, return to IDLE next cycle with no done_o, no gen_update_o and no pass handshake; flush has priority over all other events.
REQ-017 SHALL register all outputs except req_ready_o, gen_load_o, gen_stride_o, gen_update_o and the pass_* group, which decode from registered state.

Reset
REQ-018 SHALL reset state to IDLE and accumulator, counter, target, captured stride and error flag to 0.
REQ-019 SHALL drive all outputs to 0 in reset, except req_ready_o=1.
REQ-020 SHALL accept a new request the first cycle after rst_ni deasserts.

Structure
REQ-021 SHALL keep the FSM state typedef local to the module; no shared package additions are required.
REQ-022 SHALL take idx_width from cf_math_pkg.
REQ-023 SHALL be one flat module; the one-hot check uses the common-cells popcount as its only sub-module.

Verification
REQ-024 Stride 5, pass_ready_i=1: SHALL give passes 1 (offset 0, first) then 4 (offset 1, last) on consecutive cycles, then done_o with npasses_o=2, err_o=0.
REQ-025 Stride 0: SHALL give LOAD then DONE, with no pass_valid_o, npasses_o=0, err_o=0.
REQ-026 Stride 7 with pass_ready_i low 3 cycles per pass: SHALL hold pass_stride_o stable, issue one gen_update_o per accepted pass, then complete with npasses_o=3.
REQ-027 flush_i during the second pass of stride 12: SHALL return to IDLE with no done_o, then accept a new request.
REQ-028 Generator model dropping gen_valid_i after one component with popc=2: SHALL give done_o with err_o=1 and npasses_o=1.
REQ-029 rst_ni asserted mid-ISSUE: SHALL zero all outputs asynchronously and raise req_ready_o=1.
